// File: rtl/rr_hold_arbiter_if.sv
`default_nettype none
// ============================================================================
// rr_hold_arbiter_if : request/grant bundle between requesters and arbiter
// Revision: 1.0
// ============================================================================
interface rr_hold_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               hold_expired;

    modport master (output req, input gnt, gnt_valid, gnt_id, hold_expired);
    modport slave  (input req, output gnt, gnt_valid, gnt_id, hold_expired);
endinterface
`default_nettype wire

// File: rtl/rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
// rr_hold_arbiter : registered one-hot round-robin arbiter with bounded hold
// Revision: 1.0
// ============================================================================
module rr_hold_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2,
    parameter int CNT_W    = 3
) (
    input  wire logic          clock,
    input  wire logic          reset,
    rr_hold_arbiter_if.slave   bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  c_last_id   = ID_W'(NUM_REQ - 1);

    state_t             r_state, w_state;
    logic [ID_W-1:0]    r_ptr, w_ptr;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt;
    logic [ID_W-1:0]    r_gnt_id, w_gnt_id;
    logic               r_gnt_valid, w_gnt_valid;
    logic               r_hold_expired, w_hold_expired;
    logic [ID_W-1:0]    w_next_ptr;
    logic [NUM_REQ-1:0] w_others;
    logic [ID_W:0]      w_sel;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] r,
                                           input logic [ID_W-1:0]    start);
        logic [ID_W:0] res;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(start) + k) % NUM_REQ;
            if (r[idx]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        w_state        = r_state;
        w_ptr          = r_ptr;
        w_cnt          = r_cnt;
        w_gnt_id       = r_gnt_id;
        w_gnt_valid    = r_gnt_valid;
        w_hold_expired = 1'b0;
        w_sel          = '0;
        w_next_ptr     = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + 1'b1;
        w_others       = bus.req & ~r_gnt;

        case (r_state)
            IDLE: begin
                w_sel = pick(bus.req, r_ptr);
                if (w_sel[ID_W]) begin
                    w_state     = GRANT;
                    w_gnt_id    = w_sel[ID_W-1:0];
                    w_gnt_valid = 1'b1;
                    w_cnt       = '0;
                end
            end
            GRANT: begin
                if (!bus.req[r_gnt_id]) begin
                    w_ptr = w_next_ptr;
                    w_sel = pick(bus.req, w_next_ptr);
                    w_cnt = '0;
                    if (w_sel[ID_W]) begin
                        w_gnt_id = w_sel[ID_W-1:0];
                    end else begin
                        w_state     = IDLE;
                        w_gnt_id    = '0;
                        w_gnt_valid = 1'b0;
                    end
                end else if (r_cnt == c_hold_last && |w_others) begin
                    // Owner is masked out so a contender always wins the timeout.
                    w_ptr          = w_next_ptr;
                    w_sel          = pick(w_others, w_next_ptr);
                    w_gnt_id       = w_sel[ID_W-1:0];
                    w_cnt          = '0;
                    w_hold_expired = 1'b1;
                end else if (r_cnt != c_hold_last) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase

        w_gnt = w_gnt_valid ? (NUM_REQ'(1) << w_gnt_id) : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_gnt          <= '0;
            r_gnt_id       <= '0;
            r_gnt_valid    <= 1'b0;
            r_hold_expired <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_ptr          <= w_ptr;
            r_cnt          <= w_cnt;
            r_gnt          <= w_gnt;
            r_gnt_id       <= w_gnt_id;
            r_gnt_valid    <= w_gnt_valid;
            r_hold_expired <= w_hold_expired;
        end
    end

    assign bus.gnt          = r_gnt;
    assign bus.gnt_valid    = r_gnt_valid;
    assign bus.gnt_id       = r_gnt_id;
    assign bus.hold_expired = r_hold_expired;
endmodule
`default_nettype wire

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter that shares one resource between NUM_REQ requesters.
- Generalises the 2-input req/gnt arbiter: N requesters, fair rotation, and a bounded grant-hold time so no requester can starve the others.
- Sits between requester blocks and the shared resource. Grants are registered and one-hot.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester is pending (>=1).
- ID_W, 2, width of gnt_id; must be >= clog2(NUM_REQ).
- CNT_W, 3, width of hold counter; must hold MAX_HOLD-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request vector; bit i held high while requester i wants the resource.
- gnt  output  NUM_REQ  one-hot grant vector, registered.
- gnt_valid  output  1  high when any gnt bit is high.
- gnt_id  output  ID_W  index of the current owner; 0 when gnt_valid=0.
- hold_expired  output  1  one-cycle pulse on the cycle after a grant was revoked by hold timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt=0, gnt_valid=0, gnt_id=0, hold_expired=0.
  - state=IDLE, hold_cnt=0, ptr=0.
  - Asserting reset mid-grant drops gnt immediately, without waiting for a clock edge.
- State machine has two states, IDLE and GRANT. All outputs are registered; there is no combinational path from req to gnt.
- Winner selection: the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
- IDLE:
  - If req != 0 at a rising edge: state=GRANT, owner=winner, gnt=onehot(owner), hold_cnt=0.
  - Latency is exactly 1 cycle from the edge that samples req to gnt high.
  - If req == 0: stay in IDLE.
- GRANT:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - Release: at an edge with req[owner]=0.
    - ptr=owner+1 (mod NUM_REQ).
    - If any other req is high, the new winner is granted at that same edge: gapless handover, hold_cnt=0.
    - Otherwise go to IDLE with gnt=0.
  - Expiry: at an edge with req[owner]=1, hold_cnt==MAX_HOLD-1 and another req bit high.
    - ptr=owner+1; the owner is excluded from that selection.
    - The winner is granted, hold_cnt=0, hold_expired=1 for one cycle.
    - The revoked owner competes again normally.
  - Owner still requesting with no contender: the grant is kept indefinitely and hold_cnt saturates.
- Fairness: after any handover the previous owner has the lowest priority. Any requester holding req high is granted within (NUM_REQ-1)*MAX_HOLD+1 cycles.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_id matches gnt.
  - gnt never changes except at a rising edge or on asynchronous reset.
- A req glitch shorter than a clock period between edges is ignored; only sampled values matter.
- Wrap-around: with NUM_REQ=4, owner=3, release moves ptr to 0.

Test Plan:
NUM_REQ=4, MAX_HOLD=4 for all scenarios.
1. Reset then idle: reset=0 for 2 cycles with req=4'b1111, then release reset. Required: gnt=0 throughout reset; gnt=4'b0001, gnt_id=0 one cycle after the first edge with reset high.
2. Single request: req=4'b0100 for 3 cycles then 0. Required: gnt=4'b0100 from the next edge for 3 cycles, then gnt=0 and gnt_valid=0, with no extra cycle.
3. Rotation: req=4'b1111 and each owner drops its req after 1 grant cycle. Required: grant order 0,1,2,3 with no idle gaps between grants.
4. Hold timeout: req[0]=1 held, req[2] raised at cycle 1. Required: gnt=4'b0001 for exactly 4 cycles, then gnt=4'b0100 with hold_expired=1 for 1 cycle. After req[2] drops, gnt=4'b0001 again.
5. No-contender hold: req=4'b1000 held for 20 cycles. Required: gnt=4'b1000 for all 20 cycles and hold_expired never asserted.
6. Reset mid-grant: owner=1 with req=4'b0110, pulse reset low for half a cycle. Required: gnt=0 immediately; after reset releases, ptr=0, so gnt=4'b0010 (requester 1 is the first requesting from 0).
